// File: rtl/gain_ctrl_pkg.sv
// Shared types and helpers for the automatic gain controller around the
// 32-to-16-bit gain stage.
package gain_ctrl_pkg;

  localparam int SHIFT_W = 5;
  localparam int COEFF_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE,
    ST_SCAN,
    ST_DECIDE
  } agc_state_t;

  typedef struct packed {
    logic               sat;
    logic [SHIFT_W-1:0] req;
  } req_t;

  // Shift needed to bring a peak with MSB msb down to out_msb; msb=-1 is a zero peak.
  function automatic req_t calc_req(input logic signed [5:0] msb,
                                    input int out_msb,
                                    input int max_shift);
    int   raw;
    req_t r;
    raw = int'(msb) - out_msb;
    if (raw < 0) raw = 0;
    r.sat = (raw > max_shift);
    r.req = r.sat ? SHIFT_W'(max_shift) : SHIFT_W'(raw);
    return r;
  endfunction

endpackage

// File: rtl/gain_ctrl_agc_if.sv
// Link between the gain stage (master) and the AGC (slave): sample sync,
// running peak, peak clear and the shift coefficient.
interface gain_ctrl_agc_if #(
  parameter int CNT_W = 9
);
  import gain_ctrl_pkg::*;

  logic               en_sync_in;
  logic [CNT_W-1:0]   cnt_sync_in;
  logic [31:0]        max_in;
  logic               peak_clr;
  logic [COEFF_W-1:0] scaled_coeff;

  modport master (
    output en_sync_in, cnt_sync_in, max_in,
    input  peak_clr, scaled_coeff
  );

  modport slave (
    input  en_sync_in, cnt_sync_in, max_in,
    output peak_clr, scaled_coeff
  );

endinterface

// File: rtl/gain_ctrl_agc_msb_scan_serial.sv
// Bit-serial MSB finder: after i_start, tests one bit per cycle from bit 31
// down; o_done and o_msb are valid in the cycle the scan terminates.
module msb_scan_serial (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [31:0]       i_value,
  output logic signed [5:0] o_msb,
  output logic              o_done
);

  logic [4:0] r_idx;
  logic       r_active;
  logic       w_hit;

  assign w_hit  = i_value[r_idx];
  assign o_done = r_active && (w_hit || r_idx == 5'd0);
  assign o_msb  = w_hit ? $signed({1'b0, r_idx}) : -6'sd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_idx    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_idx    <= 5'd31;
    end else if (r_active) begin
      if (o_done) r_active <= 1'b0;
      else        r_idx    <= r_idx - 5'd1;
    end
  end

endmodule

// File: rtl/gain_ctrl_agc.sv
// Automatic gain controller: windows the gain stage's peak, finds its MSB,
// and commits a hysteresis-filtered right shift only at frame starts.
module gain_ctrl_agc
  import gain_ctrl_pkg::*;
#(
  parameter int CNT_W      = 9,
  parameter int FRAME_LEN  = 512,
  parameter int WIN_FRAMES = 4,
  parameter int OUT_MSB    = 14,
  parameter int MAX_SHIFT  = 16,
  parameter int INIT_SHIFT = 8,
  parameter int DEC_EVALS  = 3,
  parameter int PEAK_LAT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  gain_ctrl_agc_if.slave     gs,
  input  logic               auto_en,
  input  logic [SHIFT_W-1:0] manual_coeff,
  output logic               coeff_upd,
  output logic               sat_flag,
  output logic               busy
);

  localparam int FC_W   = (WIN_FRAMES > 1) ? $clog2(WIN_FRAMES) : 1;
  localparam int WAIT_W = (PEAK_LAT > 1) ? $clog2(PEAK_LAT) : 1;
  localparam int DEC_W  = $clog2(DEC_EVALS + 1);

  agc_state_t        r_state;
  logic [FC_W-1:0]   r_frame_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [31:0]       r_peak;
  logic signed [5:0] r_msb;
  logic              r_peak_clr;
  logic              r_busy;
  logic [SHIFT_W-1:0] r_coeff;
  logic               r_coeff_upd;
  logic [SHIFT_W-1:0] r_pending;
  logic               r_pending_vld;
  logic [DEC_W-1:0]   r_dec_cnt;
  logic               r_sat;

  logic               w_frame_end;
  logic               w_frame_start;
  logic               w_win_end;
  logic               w_scan_done;
  logic signed [5:0]  w_scan_msb;
  logic [SHIFT_W-1:0] w_manual;
  req_t               w_req;

  assign w_frame_end   = gs.en_sync_in && (gs.cnt_sync_in == CNT_W'(FRAME_LEN - 1));
  assign w_frame_start = gs.en_sync_in && (gs.cnt_sync_in == '0);
  assign w_win_end     = w_frame_end && (r_frame_cnt == FC_W'(WIN_FRAMES - 1));
  assign w_manual      = (manual_coeff > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : manual_coeff;
  assign w_req         = calc_req(r_msb, OUT_MSB, MAX_SHIFT);

  always_ff @(posedge clk) begin
    if (rst)              r_frame_cnt <= '0;
    else if (w_frame_end) r_frame_cnt <= w_win_end ? '0 : r_frame_cnt + 1'b1;
  end

  msb_scan_serial u_scan (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_state == ST_CAPTURE),
    .i_value (r_peak),
    .o_msb   (w_scan_msb),
    .o_done  (w_scan_done)
  );

  // peak_clr and busy are set on entry to their states so they are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_peak     <= '0;
      r_msb      <= '0;
      r_peak_clr <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_peak_clr <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_win_end) begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= '0;
        end
        ST_WAIT: if (r_wait_cnt == WAIT_W'(PEAK_LAT - 1)) begin
          r_state    <= ST_CAPTURE;
          r_peak_clr <= 1'b1;
          r_busy     <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        ST_CAPTURE: begin
          r_peak  <= gs.max_in;
          r_state <= ST_SCAN;
        end
        ST_SCAN: if (w_scan_done) begin
          r_msb   <= w_scan_msb;
          r_busy  <= 1'b0;
          r_state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          r_state    <= w_win_end ? ST_WAIT : ST_IDLE;
          r_wait_cnt <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A decision made in the same cycle as a commit is assigned last and survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coeff       <= SHIFT_W'(INIT_SHIFT);
      r_coeff_upd   <= 1'b0;
      r_pending     <= '0;
      r_pending_vld <= 1'b0;
      r_dec_cnt     <= '0;
      r_sat         <= 1'b0;
    end else begin
      r_coeff_upd <= 1'b0;
      if (w_frame_start) begin
        if (!auto_en) begin
          if (w_manual != r_coeff) begin
            r_coeff     <= w_manual;
            r_coeff_upd <= 1'b1;
          end
        end else if (r_pending_vld) begin
          r_pending_vld <= 1'b0;
          if (r_pending != r_coeff) begin
            r_coeff     <= r_pending;
            r_coeff_upd <= 1'b1;
          end
        end
      end
      if (r_state == ST_DECIDE) begin
        if (w_req.sat) r_sat <= 1'b1;
        if (w_req.req > r_coeff) begin
          r_pending     <= w_req.req;
          r_pending_vld <= 1'b1;
          r_dec_cnt     <= '0;
        end else if (w_req.req < r_coeff) begin
          if (r_dec_cnt == DEC_W'(DEC_EVALS - 1)) begin
            r_pending     <= r_coeff - 1'b1;
            r_pending_vld <= 1'b1;
            r_dec_cnt     <= '0;
          end else begin
            r_dec_cnt <= r_dec_cnt + 1'b1;
          end
        end else begin
          r_dec_cnt     <= '0;
          r_pending_vld <= 1'b0;
        end
      end
    end
  end

  assign gs.peak_clr     = r_peak_clr;
  assign gs.scaled_coeff = COEFF_W'(r_coeff);
  assign coeff_upd       = r_coeff_upd;
  assign sat_flag        = r_sat;
  assign busy            = r_busy;

  // The peak pipeline is idle again well before the next window can end.
  a_win_end_idle: assert property (@(posedge clk) disable iff (rst)
    w_win_end |-> (r_state == ST_IDLE || r_state == ST_DECIDE));

endmodule

// File: tb/tb_gain_ctrl_agc.sv
// Self-checking bench for gain_ctrl_agc: window vector table with a
// coeff_upd scoreboard, plus reset-in-scan and manual-mode sequences.
module tb_gain_ctrl_agc;
  import gain_ctrl_pkg::*;

  localparam int FRAME_LEN = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       auto_en;
  logic [4:0] manual_coeff;
  logic       coeff_upd;
  logic       sat_flag;
  logic       busy;

  gain_ctrl_agc_if #(.CNT_W(9)) gs_if ();

  gain_ctrl_agc #(
    .CNT_W(9), .FRAME_LEN(FRAME_LEN), .WIN_FRAMES(4), .OUT_MSB(14),
    .MAX_SHIFT(16), .INIT_SHIFT(8), .DEC_EVALS(3), .PEAK_LAT(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .gs           (gs_if),
    .auto_en      (auto_en),
    .manual_coeff (manual_coeff),
    .coeff_upd    (coeff_upd),
    .sat_flag     (sat_flag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_exp;
  int         clr_count = 0;
  int         busy_run = 0;
  int         last_busy_len = 0;
  int         clr_base;
  bit         fired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every coeff_upd pulse must match the next queued value.
  always @(negedge clk) begin
    if (gs_if.peak_clr) clr_count++;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run      = 0;
    end
    if (coeff_upd) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected coeff_upd: scaled_coeff=%0d expected no pulse", gs_if.scaled_coeff);
      end else begin
        mon_exp = exp_q.pop_front();
        check("coeff_upd value", 32'(gs_if.scaled_coeff), 32'(mon_exp));
      end
    end
  end

  // One full frame of valid samples; max_in switches at sample 64 so the
  // previous window's peak is still presented when it is captured.
  task automatic drive_frame(input logic [31:0] m_early, input logic [31:0] m_late,
                             input int chg_at, input logic chg_auto, input logic [4:0] chg_man,
                             input bit rst_in_scan, output bit fired_o);
    int nb;
    nb      = 0;
    fired_o = 1'b0;
    for (int c = 0; c < FRAME_LEN; c++) begin
      if (c == chg_at) begin
        auto_en      = chg_auto;
        manual_coeff = chg_man;
      end
      gs_if.en_sync_in  = 1'b1;
      gs_if.cnt_sync_in = 9'(c);
      gs_if.max_in      = (c < 64) ? m_early : m_late;
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (rst_in_scan && !fired_o && busy) begin
        nb++;
        if (nb == 2) begin
          rst     = 1'b1;
          fired_o = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    logic [31:0] max;
    logic        auto;
    logic [4:0]  man;
    logic        u0v;
    logic [4:0]  u0;
    logic        u1v;
    logic [4:0]  u1;
    logic [4:0]  mid;
    logic [4:0]  fin;
    logic        sat;
    int          busy_len;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] prev_max;

  initial begin
    // Each record is one 4-frame window: u0/u1 are updates at the starts of
    // frames 0/1, mid is scaled_coeff after frame 0, fin after frame 3.
    vecs[0]  = '{32'h0000_3FFF, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  5'd8,  5'd8,  1'b0, 20};
    vecs[1]  = '{32'h0000_3FFF, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  5'd8,  5'd8,  1'b0, 20};
    vecs[2]  = '{32'h0000_3FFF, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  5'd8,  5'd8,  1'b0, 20};
    vecs[3]  = '{32'h0100_0000, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 5'd7,  5'd8,  5'd7,  1'b0, 9};
    vecs[4]  = '{32'hFFFF_FFFF, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 5'd10, 5'd7,  5'd10, 1'b0, 2};
    vecs[5]  = '{32'h0000_3FFF, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 5'd16, 5'd10, 5'd16, 1'b1, 20};
    vecs[6]  = '{32'h0000_0000, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  5'd16, 5'd16, 1'b1, 33};
    vecs[7]  = '{32'h0000_0000, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  5'd16, 5'd16, 1'b1, 33};
    vecs[8]  = '{32'h0000_3FFF, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 5'd15, 5'd16, 5'd15, 1'b1, 20};
    vecs[9]  = '{32'h0000_3FFF, 1'b0, 5'd20, 1'b1, 5'd16, 1'b0, 5'd0,  5'd16, 5'd16, 1'b1, 20};
    vecs[10] = '{32'h0000_3FFF, 1'b0, 5'd3,  1'b1, 5'd3,  1'b0, 5'd0,  5'd3,  5'd3,  1'b1, 20};
    vecs[11] = '{32'h0100_0000, 1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 5'd2,  5'd3,  5'd2,  1'b1, 9};
    vecs[12] = '{32'h0000_3FFF, 1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 5'd10, 5'd2,  5'd10, 1'b1, 20};

    rst               = 1'b1;
    auto_en           = 1'b1;
    manual_coeff      = 5'd0;
    gs_if.en_sync_in  = 1'b0;
    gs_if.cnt_sync_in = '0;
    gs_if.max_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset scaled_coeff", 32'(gs_if.scaled_coeff), 32'd8);
    check("reset peak_clr", 32'(gs_if.peak_clr), 32'd0);
    check("reset coeff_upd", 32'(coeff_upd), 32'd0);
    check("reset sat_flag", 32'(sat_flag), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    prev_max = vecs[0].max;
    for (int k = 0; k < 13; k++) begin
      if (vecs[k].u0v) exp_q.push_back(vecs[k].u0);
      if (vecs[k].u1v) exp_q.push_back(vecs[k].u1);
      drive_frame(prev_max, vecs[k].max, 0, vecs[k].auto, vecs[k].man, 1'b0, fired);
      check($sformatf("v%0d mid scaled_coeff", k), 32'(gs_if.scaled_coeff), 32'(vecs[k].mid));
      if (k > 0)
        check($sformatf("v%0d busy length", k), 32'(last_busy_len), 32'(vecs[k-1].busy_len));
      repeat (3) drive_frame(vecs[k].max, vecs[k].max, -1, vecs[k].auto, vecs[k].man, 1'b0, fired);
      check($sformatf("v%0d end scaled_coeff", k), 32'(gs_if.scaled_coeff), 32'(vecs[k].fin));
      check($sformatf("v%0d sat_flag", k), 32'(sat_flag), 32'(vecs[k].sat));
      check($sformatf("v%0d peak_clr count", k), 32'(clr_count), 32'(k));
      prev_max = vecs[k].max;
    end
    check("table updates consumed", 32'(exp_q.size()), 32'd0);

    // A window whose peak would raise the shift, then reset mid-scan.
    drive_frame(32'h0000_3FFF, 32'h2000_0000, -1, 1'b1, 5'd3, 1'b0, fired);
    repeat (3) drive_frame(32'h2000_0000, 32'h2000_0000, -1, 1'b1, 5'd3, 1'b0, fired);
    drive_frame(32'h2000_0000, 32'h0000_3FFF, -1, 1'b1, 5'd3, 1'b1, fired);
    check("reset issued during scan", 32'(fired), 32'd1);
    check("post-rst scaled_coeff", 32'(gs_if.scaled_coeff), 32'd8);
    check("post-rst sat_flag", 32'(sat_flag), 32'd0);
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst coeff_upd", 32'(coeff_upd), 32'd0);
    clr_base = clr_count;
    repeat (8) drive_frame(32'h0000_3FFF, 32'h0000_3FFF, -1, 1'b1, 5'd3, 1'b0, fired);
    check("post-rst peak_clr per window", 32'(clr_count - clr_base), 32'd2);
    check("post-rst coeff held", 32'(gs_if.scaled_coeff), 32'd8);

    // Manual request changed mid-frame: applied only at the next frame start.
    drive_frame(32'h0000_3FFF, 32'h0000_3FFF, 100, 1'b0, 5'd20, 1'b0, fired);
    check("manual no mid-frame change", 32'(gs_if.scaled_coeff), 32'd8);
    exp_q.push_back(5'd16);
    drive_frame(32'h0000_3FFF, 32'h0000_3FFF, -1, 1'b0, 5'd20, 1'b0, fired);
    check("manual clamped to 16", 32'(gs_if.scaled_coeff), 32'd16);
    drive_frame(32'h0000_3FFF, 32'h0000_3FFF, -1, 1'b0, 5'd20, 1'b0, fired);
    drive_frame(32'h0000_3FFF, 32'h0000_3FFF, 200, 1'b1, 5'd20, 1'b0, fired);
    exp_q.push_back(5'd15);
    drive_frame(32'h0000_3FFF, 32'h0000_3FFF, -1, 1'b1, 5'd20, 1'b0, fired);
    check("auto resumes pending step", 32'(gs_if.scaled_coeff), 32'd15);
    check("sat_flag stays clear", 32'(sat_flag), 32'd0);
    check("all updates consumed", 32'(exp_q.size()), 32'd0);

    gs_if.en_sync_in = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
